regbank_sequencer: RTL



---
 rtl/regbank_sequencer_if.sv | 53 +++++
 rtl/regbank_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/regbank_sequencer_if.sv
// ============================================================================
// Module : regbank_sequencer_if
// Request, register-bank, execution-unit and result signals of the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface regbank_sequencer_if #(
    parameter int DATA_W = 65,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_a;
    logic [ADDR_W-1:0] req_b;
    logic [ADDR_W-1:0] req_c;
    logic              req_wen;

    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic [ADDR_W-1:0] c;
    logic [DATA_W-1:0] dataC;
    logic              write;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_opa;
    logic [DATA_W-1:0] ex_opb;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    logic              err;

    modport master (
        input  req_valid, req_a, req_b, req_c, req_wen,
        input  dataA, dataB, ex_ready, res_valid, res_data,
        output req_ready, a, b, c, dataC, write,
        output ex_valid, ex_opa, ex_opb, res_ready, err
    );

    modport slave (
        output req_valid, req_a, req_b, req_c, req_wen,
        output dataA, dataB, ex_ready, res_valid, res_data,
        input  req_ready, a, b, c, dataC, write,
        input  ex_valid, ex_opa, ex_opb, res_ready, err
    );
endinterface

`default_nettype wire

// File: rtl/regbank_sequencer.sv
// ============================================================================
// Module : regbank_sequencer
// Single-request controller: read operands, issue to execution unit, write back.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regbank_sequencer #(
    parameter int DATA_W   = 65,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 33
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    regbank_sequencer_if.master  bus
);
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_WRITE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_wen;
    logic   w_a_bad;
    logic   w_b_bad;
    logic   w_c_bad;

    assign w_a_bad = ({1'b0, bus.a} >= c_num_regs);
    assign w_b_bad = ({1'b0, bus.b} >= c_num_regs);
    assign w_c_bad = ({1'b0, bus.c} >= c_num_regs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wen      <= 1'b0;
            bus.a      <= '0;
            bus.b      <= '0;
            bus.c      <= '0;
            bus.dataC  <= '0;
            bus.ex_opa <= '0;
            bus.ex_opb <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && bus.req_valid) begin
                bus.a <= bus.req_a;
                bus.b <= bus.req_b;
                bus.c <= bus.req_c;
                r_wen <= bus.req_wen;
            end
            // Out-of-range sources read as zero regardless of what the bank returns.
            if (r_state == S_READ) begin
                bus.ex_opa <= w_a_bad ? '0 : bus.dataA;
                bus.ex_opb <= w_b_bad ? '0 : bus.dataB;
            end
            if (r_state == S_WAIT_RES && bus.res_valid) begin
                bus.dataC <= bus.res_data;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        bus.req_ready = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.res_ready = 1'b0;
        bus.write     = 1'b0;
        bus.err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next_state = S_READ;
            end
            S_READ: begin
                bus.err      = w_a_bad | w_b_bad;
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                bus.ex_valid = 1'b1;
                if (bus.ex_ready) w_next_state = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                bus.res_ready = 1'b1;
                if (bus.res_valid) w_next_state = r_wen ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                bus.write    = ~w_c_bad;
                bus.err      = w_c_bad;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end
endmodule

`default_nettype wire
